matmul_result_drain: RTL and testbench
======================================

# matmul_result_drain

Output-side drain for the `matmul` engine. It captures the flat result bus `o` when the engine signals `done`, then streams the result elements out one S-bit word per transfer, row-major, over a valid/ready interface. It sits between `matmul` and the downstream consumer, which is the activation stage or the result memory writer. It also frees the engine to start its next computation as soon as the result has been latched.

## Interface

Parameters:

- `S`, 32: element width in bits.
- `H`, 4: result rows.
- `W`, 1: result columns. The number of elements per frame is N = H*W, with N ≥ 1.

Ports:

- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `done`, input, 1: `matmul` completion flag. It may be a pulse or a level; only its rising edge is used.
- `o`, input, H*W*S: `matmul` result bus. Element k = r*W + c occupies bits [(N-k)*S-1 -: S], so element 0 is in the MSBs.
- `out_data`, output, S: current element.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: the consumer accepts the word.
- `out_last`, output, 1: the current word is element N-1.
- `busy`, output, 1: a frame is held and not yet fully drained.
- `overflow`, output, 1: sticky flag. It means a `done` rising edge was dropped.
- `frame_count`, output, 16: number of completed frames, wrapping.

## Operation

Rising-edge detection:

- `done_q` is a register holding the previous value of `done`.
- `done_rise = done & ~done_q`.
- `done_q` resets to 0. If `done` is already high on the first cycle after reset, that counts as a rise.

State machine, states IDLE and SEND:

- **IDLE.** If `done_rise`: latch `o` into the shadow register `buf`, set `idx` = 0, go to SEND.
- **SEND.** `out_valid` = 1 and `out_data` = element `idx` of `buf`.
  - On a handshake (`out_valid & out_ready`) with `idx` < N-1: `idx` increments.
  - On a handshake with `idx` = N-1: `frame_count` increments, modulo 2^16.
    - If `done_rise` in the same cycle: reload `buf` from `o`, set `idx` = 0, stay in SEND. This is a back-to-back frame and there is no bubble.
    - Otherwise: go to IDLE.
  - On `done_rise` in any other SEND cycle: ignore the new frame and set `overflow` = 1. `buf` and `idx` are unchanged.

Outputs:

- `busy` = (state == SEND).
- `out_last` = `out_valid` & (`idx` == N-1).
- `out_data` is a mux on the registered `buf` and `idx`. It is stable while `out_valid & ~out_ready`.
- `overflow` clears only on reset.

Width rules:

- `idx` is $clog2(N) bits, minimum 1.
- For N = 1, every word is last.
- `o` is sampled only on the capture edge. Later changes to `o` do not affect the frame in flight.

Values of every output during reset:

- `out_valid` = 0, `out_last` = 0, `busy` = 0, `overflow` = 0, `frame_count` = 0.
- `out_data` = 0, because `buf` resets to 0.
- State is IDLE and `idx` = 0.

Reset asserted mid-frame: the frame is discarded immediately, asynchronously. Nothing resumes after reset release.

## Timing

- Capture latency: `done_rise` is sampled at edge t, and `out_valid` is high after edge t. The first word is presentable in cycle t+1.
- Throughput: one word per cycle while `out_ready` is high. With `out_ready` held high, a frame takes exactly N cycles in SEND.
- After the final handshake at edge t, `out_valid` is low in cycle t+1, unless a back-to-back reload occurred.
- `out_ready` may be high while `out_valid` is low. This has no effect.
- The block imposes no combinational path from `out_ready` to `out_valid`.
- There is a combinational path from `idx` to `out_data`, and no path from `o` or `done` to any output.

## Test plan

1. **Basic drain.** H=4, W=1, `o` = {3f800000, 40000000, 40400000, 40800000}, `done` pulsed 1 cycle, `out_ready` held high.
   - Required: `out_data` = 3f800000, 40000000, 40400000, 40800000 on 4 consecutive cycles starting 1 cycle after `done`.
   - `out_last` is high only on 40800000.
   - `frame_count` = 1, then `busy` = 0.
2. **Backpressure.** Same frame, `out_ready` toggled 1,0,0,1,0,1,1.
   - Required: each word is held stable while not ready, no word is skipped or duplicated, and the order is unchanged.
3. **Overflow.** Second `done` pulse while `idx` = 1 with a different `o`.
   - Required: `overflow` = 1 and stays high.
   - The original 4 words complete unchanged, then the block returns to IDLE with `frame_count` = 1.
4. **Back-to-back.** `done` rises on the same edge as the final handshake, new `o` = {00000001, 00000002, 00000003, 00000004}.
   - Required: 00000001 is presented the next cycle with no bubble, and `overflow` stays 0.
5. **Reset mid-frame.** Assert `rst_n` = 0 after 2 words.
   - Required: all outputs return to their reset values immediately.
   - After release, no words are emitted until a new `done` rise.
6. **Level done and geometry.** `done` held high for 10 cycles with H=2, W=3.
   - Required: exactly one frame of 6 words in row-major order, with the MSB element first.

Source files
------------

// File: rtl/matmul_result_drain.sv
`default_nettype none
// ============================================================================
// matmul_result_drain
// Latches the matmul result bus when done rises and then sends it out as
// one element per valid/ready transfer, in row-major order.
// Revision: 1.0
// ============================================================================
module matmul_result_drain #(
    parameter int S = 32,
    parameter int H = 4,
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic [H*W*S-1:0] o,
    output logic [S-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overflow,
    output logic [15:0]      frame_count
);

    localparam int N     = H * W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [N*S-1:0]     r_buf;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done_q;
    logic               r_overflow;
    logic [15:0]        r_frame_count;

    logic w_rise;
    logic w_hs;
    logic w_at_last;
    logic w_final_hs;

    assign w_rise     = done & ~r_done_q;
    assign w_hs       = (r_state == SEND) & out_ready;
    assign w_at_last  = (r_idx == LAST_IDX);
    assign w_final_hs = w_hs & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_buf         <= '0;
            r_idx         <= '0;
            r_done_q      <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_done_q <= done;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_buf   <= o;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_final_hs) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        // A rise coinciding with the final handshake starts the next frame without a bubble
                        if (w_rise) begin
                            r_buf <= o;
                            r_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_hs) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                        if (w_rise) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Element 0 lives in the MSBs of the captured bus
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                out_data = r_buf[(N-k)*S-1 -: S];
            end
        end
    end

    assign out_valid   = (r_state == SEND);
    assign busy        = (r_state == SEND);
    assign out_last    = out_valid & w_at_last;
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_drain.sv
`default_nettype none
// Directed, table-driven bench for matmul_result_drain (4x1 and 2x3 geometries).
module tb_matmul_result_drain;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         done = 1'b0;
    logic [127:0] o = '0;
    logic [31:0]  out_data;
    logic         out_valid, out_ready = 1'b0, out_last, busy, overflow;
    logic [15:0]  frame_count;

    logic         done2 = 1'b0;
    logic [191:0] o2 = '0;
    logic [31:0]  out_data2;
    logic         out_valid2, out_ready2 = 1'b0, out_last2, busy2, overflow2;
    logic [15:0]  frame_count2;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] FA = 128'h3f800000_40000000_40400000_40800000;
    localparam logic [127:0] FB = 128'h00000001_00000002_00000003_00000004;
    localparam logic [191:0] FC = 192'h00000011_00000022_00000033_00000044_00000055_00000066;

    always #5 clk = ~clk;

    matmul_result_drain #(.S(32), .H(4), .W(1)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .o(o),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overflow(overflow),
        .frame_count(frame_count)
    );

    matmul_result_drain #(.S(32), .H(2), .W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .done(done2), .o(o2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .busy(busy2), .overflow(overflow2),
        .frame_count(frame_count2)
    );

    typedef struct packed {
        bit        rs;
        bit        dn;
        bit        rdy;
        bit        osel;
        bit        ev;
        bit [31:0] ed;
        bit        el;
        bit        eo;
        bit [15:0] ef;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input bit rs, input bit dn, input bit rdy, input bit osel,
                       input bit ev, input bit [31:0] ed, input bit el,
                       input bit eo, input bit [15:0] ef);
        vec_t v;
        v.rs = rs; v.dn = dn; v.rdy = rdy; v.osel = osel; v.ev = ev;
        v.ed = ed; v.el = el; v.eo = eo; v.ef = ef;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        done = 1'b0; done2 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_fc",    {16'd0, frame_count}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] ce [6];

    initial begin
        // Basic drain
        add(1,1,1,0, 0,32'h0,0,0,0);
        add(0,0,1,0, 1,32'h3f800000,0,0,0);
        add(0,0,1,0, 1,32'h40000000,0,0,0);
        add(0,0,1,0, 1,32'h40400000,0,0,0);
        add(0,0,1,0, 1,32'h40800000,1,0,0);
        add(0,0,1,0, 0,32'h0,0,0,1);
        // Backpressure: ready 1,0,0,1,0,1,1
        add(1,1,0,0, 0,32'h0,0,0,0);
        add(0,0,1,0, 1,32'h3f800000,0,0,0);
        add(0,0,0,0, 1,32'h40000000,0,0,0);
        add(0,0,0,0, 1,32'h40000000,0,0,0);
        add(0,0,1,0, 1,32'h40000000,0,0,0);
        add(0,0,0,0, 1,32'h40400000,0,0,0);
        add(0,0,1,0, 1,32'h40400000,0,0,0);
        add(0,0,1,0, 1,32'h40800000,1,0,0);
        add(0,0,1,0, 0,32'h0,0,0,1);
        // Overflow: second rise while idx = 1
        add(1,1,1,0, 0,32'h0,0,0,0);
        add(0,0,1,0, 1,32'h3f800000,0,0,0);
        add(0,1,1,1, 1,32'h40000000,0,0,0);
        add(0,1,1,1, 1,32'h40400000,0,1,0);
        add(0,0,1,1, 1,32'h40800000,1,1,0);
        add(0,0,1,1, 0,32'h0,0,1,1);
        add(0,0,1,0, 0,32'h0,0,1,1);
        // Back-to-back reload on the final handshake
        add(1,1,1,0, 0,32'h0,0,0,0);
        add(0,0,1,0, 1,32'h3f800000,0,0,0);
        add(0,0,1,0, 1,32'h40000000,0,0,0);
        add(0,0,1,0, 1,32'h40400000,0,0,0);
        add(0,1,1,1, 1,32'h40800000,1,0,0);
        add(0,0,1,1, 1,32'h00000001,0,0,1);
        add(0,0,1,1, 1,32'h00000002,0,0,1);
        add(0,0,1,1, 1,32'h00000003,0,0,1);
        add(0,0,1,1, 1,32'h00000004,1,0,1);
        add(0,0,1,1, 0,32'h0,0,0,2);

        step();
        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            done      = tbl[i].dn;
            out_ready = tbl[i].rdy;
            o         = tbl[i].osel ? FB : FA;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_last", i),  {31'd0, out_last}, {31'd0, tbl[i].el});
            chk($sformatf("v%0d_ovf", i),   {31'd0, overflow}, {31'd0, tbl[i].eo});
            chk($sformatf("v%0d_fc", i),    {16'd0, frame_count}, {16'd0, tbl[i].ef});
            if (tbl[i].ev) chk($sformatf("v%0d_data", i), out_data, tbl[i].ed);
            step();
        end

        // Reset mid-frame after two words
        do_reset();
        out_ready = 1'b1; o = FA; done = 1'b1;
        step();
        done = 1'b0;
        chk("mr_w0", out_data, 32'h3f800000);
        step();
        chk("mr_w1", out_data, 32'h40000000);
        step();
        chk("mr_w2_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_busy",  {31'd0, busy}, 32'd0);
        chk("mr_last",  {31'd0, out_last}, 32'd0);
        chk("mr_data",  out_data, 32'd0);
        chk("mr_fc",    {16'd0, frame_count}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mr_idle%0d", k), {31'd0, out_valid}, 32'd0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk("mr_restart", out_data, 32'h3f800000);
        chk("mr_restart_valid", {31'd0, out_valid}, 32'd1);

        // Level done on a 2x3 result
        do_reset();
        ce = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        o2 = FC; out_ready2 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            done2 = (i < 10);
            chk($sformatf("g%0d_valid", i), {31'd0, out_valid2}, {31'd0, (i >= 1 && i <= 6)});
            chk($sformatf("g%0d_last", i),  {31'd0, out_last2},  {31'd0, (i == 6)});
            if (i >= 1 && i <= 6) chk($sformatf("g%0d_data", i), out_data2, ce[i-1]);
            step();
        end
        chk("g_fc",  {16'd0, frame_count2}, 32'd1);
        chk("g_ovf", {31'd0, overflow2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
